// File: rtl/mips_pkg.sv
// Shared types for the MIPS bus CPU sequencer: state encoding and exported state width.
package mips_pkg;

    localparam int STATE_W = 3;

    typedef enum logic [2:0] {
        S_RESET  = 3'd0,
        S_FETCH  = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_MDWAIT = 3'd5,
        S_HALT   = 3'd6
    } seq_state_t;

endpackage

// File: rtl/mips_cycle_sequencer_if.sv
// Avalon-style memory port between the sequencer (master) and the memory (slave).
interface mips_cycle_sequencer_if;

    logic waitrequest;
    logic mem_read;
    logic mem_write;
    logic addr_sel;

    modport master (
        input  waitrequest,
        output mem_read,
        output mem_write,
        output addr_sel
    );

    modport slave (
        output waitrequest,
        input  mem_read,
        input  mem_write,
        input  addr_sel
    );

endinterface

// File: rtl/mips_cycle_sequencer.sv
// Multi-cycle sequencer: steps the datapath through fetch/exec/mem/wb and tracks
// branch delay slots, multiply/divide stalls and halt on jump-to-zero.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RESET    | leaving reset, next cycle starts fetching
// FETCH    | instruction read at PC, held while waitrequest is high
// EXEC     | decode flags resolved; ALU ops and transfers finish here
// MEM      | load/store transfer at ALU address, held while waitrequest
// WB       | load data written to the register file
// MDWAIT   | waiting for the multiply/divide unit to go idle
// HALT     | jump to zero completed its delay slot; absorbing until reset
module mips_cycle_sequencer
    import mips_pkg::*;
#(
    parameter int STATE_W = mips_pkg::STATE_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mips_cycle_sequencer_if.master bus,
    input  logic                  data_read,
    input  logic                  data_write,
    input  logic                  write_enable,
    input  logic                  hi_wren,
    input  logic                  lo_wren,
    input  logic                  md_op,
    input  logic                  md_busy,
    input  logic                  ctl_transfer,
    input  logic                  target_is_zero,
    output logic                  ir_load,
    output logic                  pc_en,
    output logic                  pc_src,
    output logic                  target_load,
    output logic                  reg_we,
    output logic                  hi_we,
    output logic                  lo_we,
    output logic                  md_start,
    output logic                  active,
    output logic [STATE_W-1:0]    state
);

    seq_state_t state_q, state_d;
    logic       slot_pending, slot_d;
    logic       halt_pending, halt_d;
    logic       finish;
    logic       mem_read, mem_write, addr_sel;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_RESET;
            slot_pending <= 1'b0;
            halt_pending <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_pending <= slot_d;
            halt_pending <= halt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_pending;
        halt_d      = halt_pending;
        finish      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        addr_sel    = 1'b0;
        ir_load     = 1'b0;
        pc_en       = 1'b0;
        pc_src      = 1'b0;
        target_load = 1'b0;
        reg_we      = 1'b0;
        hi_we       = 1'b0;
        lo_we       = 1'b0;
        md_start    = 1'b0;
        active      = 1'b1;

        case (state_q)
            S_RESET: state_d = S_FETCH;
            S_FETCH: begin
                mem_read = 1'b1;
                if (!bus.waitrequest) begin
                    ir_load = 1'b1;
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                if (data_read || data_write) begin
                    state_d = S_MEM;
                end else if (md_op) begin
                    md_start = 1'b1;
                    state_d  = S_MDWAIT;
                end else begin
                    reg_we = write_enable;
                    hi_we  = hi_wren;
                    lo_we  = lo_wren;
                    finish = 1'b1;
                end
                // A transfer sitting in a delay slot is deliberately dropped.
                if (ctl_transfer && !slot_pending) begin
                    target_load = 1'b1;
                    slot_d      = 1'b1;
                    halt_d      = target_is_zero;
                end
            end
            S_MEM: begin
                addr_sel  = 1'b1;
                mem_read  = data_read;
                mem_write = !data_read;
                if (!bus.waitrequest) begin
                    if (data_read) state_d = S_WB;
                    else           finish  = 1'b1;
                end
            end
            S_WB: begin
                reg_we = 1'b1;
                finish = 1'b1;
            end
            S_MDWAIT: begin
                if (!md_busy) begin
                    hi_we  = hi_wren;
                    lo_we  = lo_wren;
                    finish = 1'b1;
                end
            end
            S_HALT:  active  = 1'b0;
            default: state_d = S_RESET;
        endcase

        // The branch itself falls through to its slot; the slot redirects to the target.
        if (finish) begin
            pc_en = 1'b1;
            if (slot_pending) begin
                pc_src  = 1'b1;
                slot_d  = 1'b0;
                halt_d  = 1'b0;
                state_d = halt_pending ? S_HALT : S_FETCH;
            end else begin
                state_d = S_FETCH;
            end
        end
    end

    assign bus.mem_read  = mem_read;
    assign bus.mem_write = mem_write;
    assign bus.addr_sel  = addr_sel;
    assign state         = STATE_W'(state_q);

endmodule

// File: tb/tb_mips_cycle_sequencer.sv
// Directed cycle-by-cycle bench: each step pushes its expected state/outputs to a
// scoreboard queue, popped and compared on the following falling edge.
module tb_mips_cycle_sequencer;

    localparam logic [2:0] S_RESET = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd2, S_MEM = 3'd3,
                           S_WB = 3'd4, S_MDWAIT = 3'd5, S_HALT = 3'd6;

    localparam logic [10:0] I_R  = 11'b100_0000_0000, I_W  = 11'b010_0000_0000,
                            I_DR = 11'b001_0000_0000, I_DW = 11'b000_1000_0000,
                            I_WE = 11'b000_0100_0000, I_HI = 11'b000_0010_0000,
                            I_LO = 11'b000_0001_0000, I_MD = 11'b000_0000_1000,
                            I_BY = 11'b000_0000_0100, I_CT = 11'b000_0000_0010,
                            I_TZ = 11'b000_0000_0001;

    localparam logic [11:0] O_MR = 12'h800, O_MW = 12'h400, O_AS = 12'h200, O_IR = 12'h100,
                            O_PE = 12'h080, O_PS = 12'h040, O_TL = 12'h020, O_RW = 12'h010,
                            O_HW = 12'h008, O_LW = 12'h004, O_MS = 12'h002, O_ACT = 12'h001;

    typedef struct {
        string       tag;
        logic [2:0]  st;
        logic [11:0] out;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n, data_read, data_write, write_enable, hi_wren, lo_wren;
    logic md_op, md_busy, ctl_transfer, target_is_zero;
    logic ir_load, pc_en, pc_src, target_load, reg_we, hi_we, lo_we, md_start, active;
    logic [2:0] state;
    logic [11:0] obs;

    exp_t sb[$];
    int total = 0;
    int bad   = 0;

    mips_cycle_sequencer_if bus ();

    mips_cycle_sequencer #(.STATE_W(3)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .data_read      (data_read),
        .data_write     (data_write),
        .write_enable   (write_enable),
        .hi_wren        (hi_wren),
        .lo_wren        (lo_wren),
        .md_op          (md_op),
        .md_busy        (md_busy),
        .ctl_transfer   (ctl_transfer),
        .target_is_zero (target_is_zero),
        .ir_load        (ir_load),
        .pc_en          (pc_en),
        .pc_src         (pc_src),
        .target_load    (target_load),
        .reg_we         (reg_we),
        .hi_we          (hi_we),
        .lo_we          (lo_we),
        .md_start       (md_start),
        .active         (active),
        .state          (state)
    );

    always #5 clk = ~clk;

    assign obs = {bus.mem_read, bus.mem_write, bus.addr_sel, ir_load, pc_en, pc_src,
                  target_load, reg_we, hi_we, lo_we, md_start, active};

    task automatic cyc(input string tag, input logic [10:0] in, input logic [2:0] st,
                       input logic [11:0] o);
        exp_t e;
        {rst_n, bus.waitrequest, data_read, data_write, write_enable, hi_wren, lo_wren,
         md_op, md_busy, ctl_transfer, target_is_zero} = in;
        sb.push_back('{tag, st, o});
        @(negedge clk);
        e = sb.pop_front();
        total++;
        assert (state === e.st) else begin
            bad++;
            $error("FAIL %s state: got %0d want %0d", e.tag, state, e.st);
        end
        total++;
        assert (obs === e.out) else begin
            bad++;
            $error("FAIL %s outputs: got %b want %b", e.tag, obs, e.out);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        {rst_n, bus.waitrequest, data_read, data_write, write_enable, hi_wren, lo_wren,
         md_op, md_busy, ctl_transfer, target_is_zero} = '0;
        @(posedge clk);
        #1;

        // ALU op, zero-wait
        cyc("alu_reset", I_R,        S_RESET, O_ACT);
        cyc("alu_fetch", I_R,        S_FETCH, O_MR | O_IR | O_ACT);
        cyc("alu_exec",  I_R | I_WE, S_EXEC,  O_RW | O_PE | O_ACT);

        // load with three wait cycles in MEM
        cyc("ld_fetch",  I_R,                      S_FETCH, O_MR | O_IR | O_ACT);
        cyc("ld_exec",   I_R | I_DR | I_WE,        S_EXEC,  O_ACT);
        for (int i = 0; i < 3; i++)
            cyc("ld_mem_wait", I_R | I_DR | I_WE | I_W, S_MEM, O_MR | O_AS | O_ACT);
        cyc("ld_mem",    I_R | I_DR | I_WE,        S_MEM,   O_MR | O_AS | O_ACT);
        cyc("ld_wb",     I_R | I_DR | I_WE,        S_WB,    O_RW | O_PE | O_ACT);

        // store, zero-wait
        cyc("st_fetch",  I_R,        S_FETCH, O_MR | O_IR | O_ACT);
        cyc("st_exec",   I_R | I_DW, S_EXEC,  O_ACT);
        cyc("st_mem",    I_R | I_DW, S_MEM,   O_MW | O_AS | O_PE | O_ACT);

        // taken branch with a stalled fetch, then delay slot with an ignored second branch
        cyc("br_fetch_wait", I_R | I_W,         S_FETCH, O_MR | O_ACT);
        cyc("br_fetch",      I_R,               S_FETCH, O_MR | O_IR | O_ACT);
        cyc("br_exec",       I_R | I_CT,        S_EXEC,  O_TL | O_PE | O_ACT);
        cyc("slot_fetch",    I_R,               S_FETCH, O_MR | O_IR | O_ACT);
        cyc("slot_exec",     I_R | I_WE | I_CT, S_EXEC,  O_RW | O_PE | O_PS | O_ACT);
        cyc("post_fetch",    I_R,               S_FETCH, O_MR | O_IR | O_ACT);
        cyc("post_exec",     I_R | I_WE,        S_EXEC,  O_RW | O_PE | O_ACT);

        // divide with five busy cycles
        cyc("md_fetch", I_R,                      S_FETCH, O_MR | O_IR | O_ACT);
        cyc("md_exec",  I_R | I_MD | I_HI | I_LO, S_EXEC,  O_MS | O_ACT);
        for (int i = 0; i < 5; i++)
            cyc("md_busy", I_R | I_MD | I_HI | I_LO | I_BY, S_MDWAIT, O_ACT);
        cyc("md_done",  I_R | I_MD | I_HI | I_LO, S_MDWAIT, O_HW | O_LW | O_PE | O_ACT);

        // reset mid-store inside a delay slot; slot flag must not survive reset
        cyc("rs_fetch",    I_R,               S_FETCH, O_MR | O_IR | O_ACT);
        cyc("rs_br_exec",  I_R | I_CT,        S_EXEC,  O_TL | O_PE | O_ACT);
        cyc("rs_fetch2",   I_R,               S_FETCH, O_MR | O_IR | O_ACT);
        cyc("rs_st_exec",  I_R | I_DW,        S_EXEC,  O_ACT);
        cyc("rs_st_wait",  I_R | I_DW | I_W,  S_MEM,   O_MW | O_AS | O_ACT);
        cyc("rs_assert",   I_DW | I_W,        S_MEM,   O_MW | O_AS | O_ACT);
        cyc("rs_reset",    I_R,               S_RESET, O_ACT);
        cyc("rs_fetch3",   I_R,               S_FETCH, O_MR | O_IR | O_ACT);
        cyc("rs_alu_exec", I_R | I_WE,        S_EXEC,  O_RW | O_PE | O_ACT);

        // jump to zero: halts after its delay slot
        cyc("jz_fetch",      I_R,               S_FETCH, O_MR | O_IR | O_ACT);
        cyc("jz_exec",       I_R | I_CT | I_TZ, S_EXEC,  O_TL | O_PE | O_ACT);
        cyc("jz_slot_fetch", I_R,               S_FETCH, O_MR | O_IR | O_ACT);
        cyc("jz_slot_exec",  I_R | I_WE,        S_EXEC,  O_RW | O_PE | O_PS | O_ACT);
        for (int i = 0; i < 10; i++)
            cyc("halt", I_R | (i[0] ? I_W : 11'b0), S_HALT, 12'h000);

        // reset leaves HALT
        cyc("halt_rst",   11'b0, S_HALT,  12'h000);
        cyc("halt_exit",  I_R,   S_RESET, O_ACT);
        cyc("halt_fetch", I_R,   S_FETCH, O_MR | O_IR | O_ACT);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mips_cycle_sequencer.md
# mips_cycle_sequencer

Multi-cycle state sequencer for the MIPS bus CPU: it takes the per-instruction decode flags from `control` and memory-bus handshake signals, and steps the datapath through fetch, execute, memory and write-back. It also owns branch-delay-slot bookkeeping, multiply/divide stalls and the halt-on-jump-to-zero condition. It sits between `control`, the PC/IR registers, the register file, the HI/LO unit and the Avalon-style memory port.

## Interface
- `STATE_W`, default 3: width of the exported state code.

- `clk  in  1`: single clock; all state changes on the rising edge.
- `rst_n  in  1`: reset is synchronous and active-low.
- `waitrequest  in  1`: memory stall. The current bus transfer completes in the cycle it is low.
- `data_read  in  1`: decoded load instruction, from `control`.
- `data_write  in  1`: decoded store instruction.
- `write_enable  in  1`: instruction writes the register file.
- `hi_wren  in  1`, `lo_wren  in  1`: instruction writes HI / LO.
- `md_op  in  1`: instruction is a multiply or divide.
- `md_busy  in  1`: multiply/divide unit still computing.
- `ctl_transfer  in  1`: branch taken, or any jump, resolved in EXEC.
- `target_is_zero  in  1`: resolved transfer target equals 0.
- `mem_read  out  1`, `mem_write  out  1`: bus strobes.
- `addr_sel  out  1`: bus address source; 0 = PC, 1 = ALU result.
- `ir_load  out  1`: capture the instruction register.
- `pc_en  out  1`: update the PC.
- `pc_src  out  1`: PC source; 0 = PC+4, 1 = saved target.
- `target_load  out  1`: capture the transfer target register.
- `reg_we  out  1`, `hi_we  out  1`, `lo_we  out  1`: qualified write enables.
- `md_start  out  1`: one-cycle start pulse to the multiply/divide unit.
- `active  out  1`: CPU running; low once halted.
- `state  out  STATE_W`: current state code, for debug.

## Operation
- States and codes: RESET=0, FETCH=1, EXEC=2, MEM=3, WB=4, MDWAIT=5, HALT=6.
- While `rst_n`=0 at an edge:
  - state goes to RESET;
  - delay-slot flags `slot_pending` and `halt_pending` are cleared.
- In RESET:
  - all outputs are 0 except `active`=1;
  - the next state is always FETCH.
- FETCH:
  - drives `mem_read`=1, `addr_sel`=0;
  - stays in FETCH while `waitrequest`=1;
  - when `waitrequest`=0, pulses `ir_load` and goes to EXEC.
- EXEC (one cycle), checked in this priority order:
  1. `data_read` → MEM, as a load.
  2. `data_write` → MEM, as a store.
  3. `md_op` → pulse `md_start`, go to MDWAIT.
  4. Otherwise → `reg_we`=`write_enable`, `hi_we`=`hi_wren`, `lo_we`=`lo_wren`; instruction finishes.
- Control transfers in EXEC: if `ctl_transfer`=1 and `slot_pending`=0:
  - pulse `target_load`;
  - set `slot_pending`;
  - set `halt_pending` = `target_is_zero`.
- Branch inside a delay slot (`slot_pending`=1): `target_load` is suppressed and the second transfer is ignored.
- MEM:
  - load drives `mem_read`=1, `addr_sel`=1;
  - store drives `mem_write`=1, `addr_sel`=1;
  - stays in MEM while `waitrequest`=1;
  - on `waitrequest`=0: a load goes to WB, a store finishes.
- WB (one cycle): `reg_we`=1; instruction finishes.
- MDWAIT:
  - holds while `md_busy`=1;
  - on the cycle `md_busy`=0: `hi_we`=`hi_wren`, `lo_we`=`lo_wren`; instruction finishes.
- On the final cycle of every instruction, `pc_en`=1 and the source is chosen:
  - Branch instruction itself (`slot_pending` not yet set): `pc_src`=0. The delay slot is fetched sequentially.
  - Delay-slot instruction (`slot_pending`=1): `pc_src`=1, and `slot_pending` clears.
  - If `halt_pending` was also set, go to HALT instead of FETCH.
  - All other finishes: `pc_src`=0, next state FETCH.
- HALT:
  - absorbing until reset;
  - `active`=0 and all other outputs 0.

## Timing
- Mealy outputs, combinational from state and inputs; state and flags are registered.
- Minimum cycles per instruction with `waitrequest` low:
  - ALU op: 2 (FETCH, EXEC);
  - store: 3;
  - load: 4;
  - multiply/divide: 3 + busy cycles.
- `waitrequest` may stay high indefinitely; the strobes and `addr_sel` must hold stable throughout.
- `md_busy` is sampled starting the cycle after `md_start`.
- Reset asserted mid-transfer: strobes drop in the cycle after the sampling edge, and no write enable fires.

## Structure
- Shared package `mips_pkg`: `seq_state_t` enum with the codes above, and the `STATE_W` constant.
- Purely one FSM with two flag registers; no sub-modules.

## Test plan
- ALU op, zero-wait memory, after reset:
  - state sequence RESET,FETCH,EXEC,FETCH;
  - `ir_load` at cycle 1;
  - `reg_we`, `pc_en` with `pc_src`=0 at cycle 2.
- Load with `waitrequest` high for 3 cycles in MEM:
  - `mem_read`=1, `addr_sel`=1 held for 4 cycles;
  - then WB with `reg_we`=1 for exactly one cycle.
- Taken branch, then delay slot:
  - `target_load` pulse in the branch's EXEC;
  - branch finishes with `pc_src`=0;
  - slot finishes with `pc_src`=1.
- Jump with `target_is_zero`=1:
  - after the delay-slot EXEC, state=HALT and `active`=0;
  - no further `mem_read` for 10 cycles.
- Divide:
  - `md_start` pulses once;
  - `md_busy` high for 5 cycles keeps MDWAIT;
  - `hi_we`=`lo_we`=1 in the cycle `md_busy` falls.
- `rst_n` low during a store with `waitrequest` high:
  - next cycle state=RESET and `mem_write`=0;
  - the following cycle is FETCH.
